// File: rtl/uart_rx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo_if
// Brief   : Receive-byte valid/ready stream from the UART RX FIFO to the CPU.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : 8N1 UART receiver with mid-bit sampling, sticky error flags and
//           a first-word fall-through receive FIFO drained by valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_rxd,
  input  wire logic          i_err_clr,
  output logic               o_frame_err,
  output logic               o_overrun,
  uart_rx_fifo_if.master     o_rx
);

  localparam int c_clks_per_bit = CLK_FREQ_HZ / BAUD;
  localparam int CW             = $clog2(c_clks_per_bit) + 1;
  localparam int PW             = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] c_half_last = CW'(c_clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(c_clks_per_bit - 1);
  localparam logic [CW-1:0] c_ccnt_one  = CW'(1);
  localparam logic [PW-1:0] c_ptr_one   = PW'(1);
  localparam logic [PW:0]   c_cnt_one   = (PW+1)'(1);
  localparam logic [PW:0]   c_depth     = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_ccnt, w_ccnt_nxt;
  logic [2:0]    r_bcnt, w_bcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_seen_high, w_seen_nxt;
  logic          w_push_req, w_ferr_set;
  logic          w_rx_s;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr, w_rd_nxt;
  logic [PW:0]   r_count;
  logic [7:0]    r_data;
  logic          r_frame_err, r_overrun;
  logic          w_valid, w_full, w_pop, w_do_push, w_ovr_set;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ccnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_seen_high <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ccnt      <= w_ccnt_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_seen_high <= w_seen_nxt;
    end
  end

  // seen_high is only refreshed in IDLE and at the stop-bit sample, so a
  // held-low line (break) cannot restart a frame until it returns high.
  always_comb begin
    w_state_nxt = r_state;
    w_ccnt_nxt  = r_ccnt + c_ccnt_one;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_seen_nxt  = r_seen_high;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ccnt_nxt = '0;
        if (w_rx_s) begin
          w_seen_nxt = 1'b1;
        end else if (r_seen_high) begin
          w_seen_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_ccnt == c_half_last) begin
          w_ccnt_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_ccnt == c_bit_last) begin
          w_ccnt_nxt  = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_bcnt_nxt  = r_bcnt + 3'd1;
          if (r_bcnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_ccnt == c_bit_last) begin
          w_ccnt_nxt  = '0;
          w_seen_nxt  = w_rx_s;
          w_push_req  = w_rx_s;
          w_ferr_set  = ~w_rx_s;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == c_depth);
  assign w_pop     = w_valid & o_rx.ready;
  assign w_do_push = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;
  assign w_rd_nxt  = w_pop ? r_rd_ptr + c_ptr_one : r_rd_ptr;

  // DATA is a register tracking the post-update head; a byte pushed into the
  // slot that becomes the head must bypass the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      r_rd_ptr <= w_rd_nxt;
      if (w_do_push && !w_pop)      r_count <= r_count + c_cnt_one;
      else if (!w_do_push && w_pop) r_count <= r_count - c_cnt_one;
      if (w_do_push || w_pop)
        r_data <= (w_do_push && (w_rd_nxt == r_wr_ptr)) ? r_shift : r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)     r_frame_err <= 1'b1;
      else if (i_err_clr) r_frame_err <= 1'b0;
      if (w_ovr_set)      r_overrun   <= 1'b1;
      else if (i_err_clr) r_overrun   <= 1'b0;
    end
  end

  assign o_rx.data   = r_data;
  assign o_rx.valid  = w_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire
